param_mem_server: RTL and testbench

//  Weight/bias parameter store with two sides. Host side: a streaming load port fills the weight and bias arrays in a fixed order.

---
 rtl/param_mem_server.sv | 144 ++++++++++++++
 tb/tb_param_mem_server.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/param_mem_server.sv
// Weight/bias store: a host streaming loader fills W/B in fixed order; the engine reads them by (n, i).
// Read latency 1 cycle (rd_valid pulse); reads are dropped while a load is in progress.
// Load side accepts one word per cycle whenever ld_ready is high; ld_ready drops outside LOAD_W/LOAD_B.
module param_mem_server #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 6,
    parameter int MAX_N  = 32,
    parameter int MAX_I  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              weight_en,
    input  logic              bias_en,
    input  logic [IDX_W-1:0]  n,
    input  logic [IDX_W-1:0]  i,
    output logic [DATA_W-1:0] wt_in,
    output logic [DATA_W-1:0] bias_in,
    output logic              rd_valid,
    input  logic              ld_start,
    input  logic [IDX_W-1:0]  ld_n_count,
    input  logic [IDX_W-1:0]  ld_i_count,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              busy
);
    localparam int W_DEPTH = MAX_N * MAX_I;
    localparam int W_AW    = $clog2(W_DEPTH);
    localparam int B_AW    = $clog2(MAX_N);
    localparam logic [IDX_W-1:0] MAX_N_C = IDX_W'(MAX_N);
    localparam logic [IDX_W-1:0] MAX_I_C = IDX_W'(MAX_I);
    localparam logic [W_AW-1:0]  MAX_I_A = W_AW'(MAX_I);

    typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_B, DONE} state_t;

    state_t            state;
    logic [IDX_W-1:0]  n_cnt, i_cnt;
    logic [IDX_W-1:0]  wn, wi, bn;
    logic [DATA_W-1:0] w_mem [W_DEPTH];
    logic [DATA_W-1:0] b_mem [MAX_N];

    logic              accept;
    logic [IDX_W-1:0]  sat_n, sat_i;
    logic [W_AW-1:0]   w_wr_addr, w_rd_addr;
    logic              n_ok, i_ok;

    assign ld_ready  = (state == LOAD_W) || (state == LOAD_B);
    assign busy      = (state != IDLE);
    assign accept    = ld_valid && ld_ready;
    assign sat_n     = (ld_n_count > MAX_N_C) ? MAX_N_C : ld_n_count;
    assign sat_i     = (ld_i_count > MAX_I_C) ? MAX_I_C : ld_i_count;
    assign w_wr_addr = W_AW'(wn) * MAX_I_A + W_AW'(wi);
    assign w_rd_addr = W_AW'(n) * MAX_I_A + W_AW'(i);
    assign n_ok      = (n < MAX_N_C);
    assign i_ok      = (i < MAX_I_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            n_cnt   <= '0;
            i_cnt   <= '0;
            wn      <= '0;
            wi      <= '0;
            bn      <= '0;
            ld_done <= 1'b0;
        end else begin
            ld_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ld_start) begin
                        n_cnt <= sat_n;
                        i_cnt <= sat_i;
                        wn    <= '0;
                        wi    <= '0;
                        bn    <= '0;
                        // Empty weight plane skips straight to biases; no neurons means nothing to load.
                        if (sat_n == '0)
                            state <= DONE;
                        else if (sat_i == '0)
                            state <= LOAD_B;
                        else
                            state <= LOAD_W;
                    end
                end
                LOAD_W: begin
                    if (accept) begin
                        if (wi == i_cnt - 1'b1) begin
                            wi <= '0;
                            if (wn == n_cnt - 1'b1) begin
                                wn    <= '0;
                                state <= LOAD_B;
                            end else begin
                                wn <= wn + 1'b1;
                            end
                        end else begin
                            wi <= wi + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        if (bn == n_cnt - 1'b1) begin
                            bn    <= '0;
                            state <= DONE;
                        end else begin
                            bn <= bn + 1'b1;
                        end
                    end
                end
                DONE: begin
                    ld_done <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array contents survive reset; only the write strobe is gated.
    always_ff @(posedge clk) begin
        if (!rst && accept && state == LOAD_W)
            w_mem[w_wr_addr] <= ld_data;
        if (!rst && accept && state == LOAD_B)
            b_mem[B_AW'(bn)] <= ld_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wt_in    <= '0;
            bias_in  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (!busy && (weight_en || bias_en)) begin
                rd_valid <= 1'b1;
                if (weight_en)
                    wt_in <= (n_ok && i_ok) ? w_mem[w_rd_addr] : '0;
                if (bias_en)
                    bias_in <= n_ok ? b_mem[B_AW'(n)] : '0;
            end
        end
    end
endmodule

// File: tb/tb_param_mem_server.sv
// Directed bench for param_mem_server: loads, reads, busy gating, reset mid-load.
module tb_param_mem_server;
    logic        clk = 1'b0;
    logic        rst;
    logic        weight_en, bias_en;
    logic [5:0]  n, i;
    logic [15:0] wt_in, bias_in;
    logic        rd_valid;
    logic        ld_start;
    logic [5:0]  ld_n_count, ld_i_count;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_ready, ld_done, busy;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] wq[$];

    param_mem_server dut (
        .clk(clk), .rst(rst),
        .weight_en(weight_en), .bias_en(bias_en), .n(n), .i(i),
        .wt_in(wt_in), .bias_in(bias_in), .rd_valid(rd_valid),
        .ld_start(ld_start), .ld_n_count(ld_n_count), .ld_i_count(ld_i_count),
        .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_done(ld_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Streams wq[0..nw-1]; optional idle cycle between words. Checks ld_done timing.
    task automatic load_run(input logic [5:0] nc, input logic [5:0] ic, input int nw,
                            input bit tgl, input string tag);
        int early = 0;
        ld_n_count = nc;
        ld_i_count = ic;
        ld_start   = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int k = 0; k < nw; k++) begin
            ld_valid = 1'b1;
            ld_data  = wq[k];
            tick();
            if (ld_done) early++;
            if (tgl && k < nw - 1) begin
                ld_valid = 1'b0;
                tick();
                if (ld_done) early++;
            end
        end
        ld_valid = 1'b0;
        check({tag, "_early_done"}, early, 0);
        check({tag, "_busy_in_done"}, busy, 1);
        tick();
        check({tag, "_ld_done"}, ld_done, 1);
        check({tag, "_busy_after"}, busy, 0);
        tick();
        check({tag, "_ld_done_pulse"}, ld_done, 0);
    endtask

    task automatic rd(input logic we, input logic be, input logic [5:0] nn, input logic [5:0] ii);
        weight_en = we;
        bias_en   = be;
        n         = nn;
        i         = ii;
        tick();
        weight_en = 1'b0;
        bias_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; weight_en = 0; bias_en = 0; n = 0; i = 0;
        ld_start = 0; ld_n_count = 0; ld_i_count = 0; ld_valid = 0; ld_data = 0;
        tick();
        tick();
        check("rst_wt_in", wt_in, 0);
        check("rst_bias_in", bias_in, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_ld_done", ld_done, 0);
        rst = 1'b0;
        tick();

        // Basic load: 2 neurons x 3 inputs, then two biases
        wq = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd100, 16'd200};
        load_run(6'd2, 6'd3, 8, 1'b0, "load2x3");
        rd(1, 0, 6'd1, 6'd2);
        check("rd_w_1_2", wt_in, 6);
        check("rd_w_1_2_vld", rd_valid, 1);
        rd(0, 1, 6'd1, 6'd0);
        check("rd_b_1", bias_in, 200);

        // Same load with gaps in ld_valid
        wq = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd100, 16'd200};
        load_run(6'd2, 6'd3, 8, 1'b1, "load_gap");
        rd(1, 0, 6'd0, 6'd0);
        check("gap_w_0_0", wt_in, 1);
        rd(1, 0, 6'd1, 6'd0);
        check("gap_w_1_0", wt_in, 4);
        rd(0, 1, 6'd0, 6'd0);
        check("gap_b_0", bias_in, 100);

        // Combined read, single rd_valid pulse, then out-of-range
        rd(1, 1, 6'd0, 6'd1);
        check("both_wt", wt_in, 2);
        check("both_bias", bias_in, 100);
        check("both_vld", rd_valid, 1);
        tick();
        check("both_vld_pulse", rd_valid, 0);
        rd(1, 0, 6'd40, 6'd0);
        check("oob_wt", wt_in, 0);
        check("oob_vld", rd_valid, 1);
        rd(0, 1, 6'd40, 6'd0);
        check("oob_bias", bias_in, 0);

        // Reads and ld_start while loading are ignored
        rd(1, 0, 6'd1, 6'd2);
        check("pre_busy_wt", wt_in, 6);
        ld_n_count = 6'd2; ld_i_count = 6'd3; ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check("loadw_ready", ld_ready, 1);
        ld_valid = 1; ld_data = 16'd11; tick();
        ld_data = 16'd12; tick();
        ld_valid = 0;
        rd(1, 0, 6'd0, 6'd0);
        check("busy_rd_vld", rd_valid, 0);
        check("busy_rd_wt", wt_in, 6);
        ld_n_count = 6'd0; ld_start = 1'b1; ld_valid = 1; ld_data = 16'd13;
        tick();
        ld_start = 1'b0;
        check("restart_ignored_busy", busy, 1);
        wq = '{16'd14, 16'd15, 16'd16, 16'd300, 16'd400};
        for (int k = 0; k < 5; k++) begin
            ld_data = wq[k];
            tick();
        end
        ld_valid = 0;
        check("s5_busy_in_done", busy, 1);
        tick();
        check("s5_ld_done", ld_done, 1);
        tick();
        rd(1, 0, 6'd0, 6'd1);
        check("s5_w_0_1", wt_in, 12);
        rd(1, 0, 6'd1, 6'd2);
        check("s5_w_1_2", wt_in, 16);
        rd(0, 1, 6'd1, 6'd0);
        check("s5_b_1", bias_in, 400);

        // Reset after three words
        ld_n_count = 6'd2; ld_i_count = 6'd3; ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        wq = '{16'd21, 16'd22, 16'd23};
        ld_valid = 1;
        for (int k = 0; k < 3; k++) begin
            ld_data = wq[k];
            tick();
        end
        ld_valid = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_ready", ld_ready, 0);
        check("midrst_done", ld_done, 0);
        tick();
        check("midrst_done_later", ld_done, 0);
        rd(1, 0, 6'd0, 6'd0);
        check("midrst_w0", wt_in, 21);
        rd(1, 0, 6'd0, 6'd1);
        check("midrst_w1", wt_in, 22);
        rd(1, 0, 6'd0, 6'd2);
        check("midrst_w2", wt_in, 23);
        rd(1, 0, 6'd1, 6'd0);
        check("midrst_w_1_0_kept", wt_in, 14);

        // Zero-neuron load: straight to DONE
        ld_n_count = 6'd0; ld_i_count = 6'd3; ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check("zero_n_done_early", ld_done, 0);
        check("zero_n_busy", busy, 1);
        check("zero_n_ready", ld_ready, 0);
        tick();
        check("zero_n_done", ld_done, 1);
        check("zero_n_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
